// File: rtl/mmio_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_pkg
//   Shared definitions for the memory-mapped UART transmitter: register
//   offsets relative to the block base address, the STATUS word layout and
//   the serialiser FSM state encodings.
// -----------------------------------------------------------------------------
package mmio_uart_tx_pkg;

   // Register offsets from BASE_ADDR
   localparam logic [31:0] DATA_OFFSET   = 32'h0000_0000;
   localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

   // STATUS word as seen by firmware on a lw; busy is bit 0.
   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [7:0]  count;
      logic [3:0]  rsvd_lo;
      logic        overflow;
      logic        empty;
      logic        full;
      logic        busy;
   } status_t;

   // Serialiser FSM encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
//   Small synchronous FIFO holding bytes waiting to be serialised.
//   A push into a full FIFO is still accepted when a pop happens on the same
//   edge, so a drained slot can be refilled without a bubble.
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   push_i   in   enqueue request
//   data_i   in   byte to enqueue
//   pop_i    in   dequeue request (ignored when empty)
//   data_o   out  head-of-queue byte (valid when !empty_o)
//   full_o   out  count == DEPTH
//   empty_o  out  count == 0
//   count_o  out  occupancy, 0..DEPTH
//   accept_o out  push_i was taken on this edge
// -----------------------------------------------------------------------------
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     accept_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == CNT_FULL);
   assign count_o  = count_q;
   assign data_o   = mem_q[rd_ptr_q];

   assign do_pop   = pop_i & ~empty_o;
   assign do_push  = push_i & (~full_o | do_pop);
   assign accept_o = do_push;

   // NOTE: storage has no reset; the pointers and count alone define which
   // entries are valid, and leaving the array unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   UART transmitter mapped onto the single-cycle MIPS data bus. Stores to
//   the DATA register queue a byte; a store to STATUS clears the sticky
//   overflow flag. Bytes are sent 8N1, LSB first, BAUD_DIV clocks per bit,
//   back to back with no idle gap while the queue has data.
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   Address    in   byte address from the ALU
//   WriteData  in   store data; bits [7:0] carry the byte
//   MemWrite   in   store strobe
//   MemRead    in   load strobe (not needed: reads are combinational)
//   ReadData   out  STATUS word when STATUS is addressed, else 0
//   Hit        out  DATA or STATUS addressed; selects IO in the read mux
//   TxD        out  serial line, idle high
//   TxBusy     out  frame in flight or bytes queued
// -----------------------------------------------------------------------------
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0024,
   parameter int          BAUD_DIV   = 434,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        Hit,
   output logic        TxD,
   output logic        TxBusy
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

   // Reset asserts immediately but releases two clocks after the pin rises,
   // so no flop sees the release close to an edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   // ---------------- address decode ----------------
   logic hit_data, hit_status, push_req, status_wr;

   assign hit_data   = (Address == BASE_ADDR + DATA_OFFSET);
   assign hit_status = (Address == BASE_ADDR + STATUS_OFFSET);
   assign Hit        = hit_data | hit_status;
   assign push_req   = MemWrite & hit_data;
   assign status_wr  = MemWrite & hit_status;

   // ---------------- FIFO ----------------
   logic [7:0]    fifo_data;
   logic          fifo_full, fifo_empty, fifo_accept, pop;
   logic [CW-1:0] fifo_count;

   byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (push_req),
      .data_i   (WriteData[7:0]),
      .pop_i    (pop),
      .data_o   (fifo_data),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .count_o  (fifo_count),
      .accept_o (fifo_accept)
   );

   // ---------------- sticky overflow ----------------
   logic overflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          overflow_q <= 1'b0;
      else if (status_wr)                  overflow_q <= 1'b0;
      else if (push_req && !fifo_accept)   overflow_q <= 1'b1;
   end

   // ---------------- serialiser ----------------
   logic [1:0]    state_q, state_d;
   logic [BW-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          baud_end;

   assign baud_end = (baud_cnt_q == BAUD_LAST);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_end ? '0 : baud_cnt_q + BW'(1);
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            baud_cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (baud_end) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (baud_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) state_d   = ST_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         ST_STOP: begin
            // Chain straight into the next start bit when more data is queued.
            if (baud_end) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_data;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
      end
   end

   // Line level decoded from registered state, so an async reset forces idle
   // high at once.
   always_comb begin
      case (state_q)
         ST_START: TxD = 1'b0;
         ST_DATA:  TxD = shift_q[0];
         default:  TxD = 1'b1;
      endcase
   end

   assign TxBusy = (state_q != ST_IDLE) | ~fifo_empty;

   // ---------------- read data ----------------
   status_t status;

   always_comb begin
      status          = '0;
      status.count    = 8'(fifo_count);
      status.overflow = overflow_q;
      status.empty    = fifo_empty;
      status.full     = fifo_full;
      status.busy     = TxBusy;
   end

   assign ReadData = hit_status ? status : 32'h0;

   logic unused_inputs;
   assign unused_inputs = ^{WriteData[31:8], MemRead};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled on the
//   falling edge or between edges.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE   = 32'h1001_0024;
   localparam logic [31:0] STATUS = 32'h1001_0028;
   localparam int          BD     = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;
   logic        TxD;
   logic        TxBusy;

   int n_checks = 0;
   int n_errors = 0;

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .BAUD_DIV   (BD),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .TxD       (TxD),
      .TxBusy    (TxBusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One store: inputs set after edge P, captured at edge N; returns at N+1 time unit.
   task automatic sw(input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk); #1;
      Address   = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      @(posedge clk); #1;
      MemWrite  = 1'b0;
   endtask

   // Checks one 8N1 frame whose start bit begins at the next rising edge.
   task automatic check_frame(input logic [7:0] b);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int c = 0; c < 10 * BD; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("txd byte %02h bit %0d", b, c / BD), {31'b0, TxD}, {31'b0, fr[c / BD]});
         check($sformatf("busy byte %02h cyc %0d", b, c), {31'b0, TxBusy}, 32'h1);
      end
   endtask

   initial begin
      reset     = 1'b0;
      Address   = 32'h0;
      WriteData = 32'h0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // 1: reset state
      Address = STATUS;
      MemRead = 1'b1;
      #1;
      check("reset status", ReadData, 32'h0000_0004);
      check("reset txd", {31'b0, TxD}, 32'h1);
      check("reset busy", {31'b0, TxBusy}, 32'h0);
      check("reset hit", {31'b0, Hit}, 32'h1);
      MemRead = 1'b0;

      // 2: single byte 0x55, latency and frame length
      sw(BASE, 32'hCAFE_0055);
      check("push edge txd still idle", {31'b0, TxD}, 32'h1);
      check("push edge busy", {31'b0, TxBusy}, 32'h1);
      check_frame(8'h55);
      @(posedge clk);
      @(negedge clk);
      check("busy drop after 0x55", {31'b0, TxBusy}, 32'h0);
      check("txd idle after 0x55", {31'b0, TxD}, 32'h1);

      // 3 + 4: six back-to-back pushes; sixth overflows; STATUS write clears flag
      @(posedge clk); #1;
      Address  = BASE;
      MemWrite = 1'b1;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               WriteData = {24'hABCDEF, 8'h41 + 8'(i)};
               @(posedge clk); #1;
            end
            MemWrite = 1'b0;
            Address  = STATUS;
            #1;
            check("status after overflow", ReadData, 32'h0000_040B);
            WriteData = 32'h1234_5600;
            MemWrite  = 1'b1;
            @(posedge clk); #1;
            MemWrite = 1'b0;
            check("status after clear", ReadData, 32'h0000_0403);
         end
         begin
            @(posedge clk);
            check_frame(8'h41);
            check_frame(8'h42);
            check_frame(8'h43);
            check_frame(8'h44);
            check_frame(8'h45);
         end
      join
      @(posedge clk);
      @(negedge clk);
      check("busy drop after burst", {31'b0, TxBusy}, 32'h0);
      check("txd idle after burst", {31'b0, TxD}, 32'h1);
      check("status after burst", ReadData, 32'h0000_0004);

      // 5: reset in the middle of a data bit
      sw(BASE, 32'h0000_00A5);
      sw(BASE, 32'h0000_003C);
      Address = STATUS;
      repeat (8) @(posedge clk);
      #2;
      check("mid-frame txd bit1", {31'b0, TxD}, 32'h0);
      check("mid-frame status", ReadData, 32'h0000_0101);
      #1;
      reset = 1'b0;
      #1;
      check("async reset txd", {31'b0, TxD}, 32'h1);
      check("async reset busy", {31'b0, TxBusy}, 32'h0);
      check("async reset status", ReadData, 32'h0000_0004);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("post-reset status", ReadData, 32'h0000_0004);
      repeat (20) @(negedge clk);
      check("queued byte lost txd", {31'b0, TxD}, 32'h1);
      check("queued byte lost busy", {31'b0, TxBusy}, 32'h0);

      // 6: decode boundaries
      Address = 32'h1001_0000;
      MemRead = 1'b1;
      #1;
      check("ram addr hit", {31'b0, Hit}, 32'h0);
      check("ram addr rdata", ReadData, 32'h0);
      Address = BASE;
      #1;
      check("data addr hit", {31'b0, Hit}, 32'h1);
      check("data addr rdata", ReadData, 32'h0);
      Address = BASE + 32'd8;
      #1;
      check("base+8 hit", {31'b0, Hit}, 32'h0);
      check("base+8 rdata", ReadData, 32'h0);
      MemRead = 1'b0;
      sw(32'h1001_0000, 32'h0000_0077);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check($sformatf("foreign sw txd cyc %0d", c), {31'b0, TxD}, 32'h1);
         check($sformatf("foreign sw busy cyc %0d", c), {31'b0, TxBusy}, 32'h0);
      end
      Address = STATUS;
      #1;
      check("foreign sw status", ReadData, 32'h0000_0004);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
